leiwand_rv32_wb_uart_tx: RTL
============================

Name: leiwand_rv32_wb_uart_tx

Overview:
- Wishbone slave UART transmitter on the core's data bus, next to the internal RAM.
- The top-level address decoder gates `wb_stb` for its window at 0x10000000–0x1000000F.
- CPU stores push bytes into a TX FIFO. An FSM serialises them 8N1 onto `uart_tx` at a programmable bit period.
- The bus interface is the same pipelined-Wishbone signal set the RAM uses, so the top muxes ack/stall/data per slave.

Parameters:
- `MEM_WIDTH`, 32, bus data/address width.
- `FIFO_DEPTH`, 8, TX FIFO entries; power of two, ≥2.
- `DIV_RESET`, 104, reset bit period in clk cycles (12 MHz / 115200).

Ports:
- `clk`  in  1  system clock, all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `wb_addr`  in  MEM_WIDTH  byte address; only [3:2] decoded.
- `wb_data_in`  in  MEM_WIDTH  write data from master.
- `wb_data_out`  out  MEM_WIDTH  read data to master, valid with `wb_ack`.
- `wb_we`  in  1  write enable.
- `wb_stb`  in  1  strobe, pre-gated by top decoder.
- `wb_ack`  out  1  single-cycle acknowledge.
- `wb_cyc`  in  1  bus cycle active.
- `wb_stall`  out  1  request not accepted this cycle.
- `data_write_size`  in  `HIGH_BIT_TO_FIT(4)+1`  access size in bytes (1/2/4); ignored, see Behaviour.
- `uart_tx`  out  1  serial line, idle high.
- `tx_irq`  out  1  high while FIFO empty and FSM idle.

Behaviour:
- Reset (`reset` = 0, asynchronous):
  - `wb_ack` = 0, `wb_stall` = 0, `wb_data_out` = 0.
  - `uart_tx` = 1, `tx_irq` = 1.
  - FIFO empty, DIV = `DIV_RESET`, FSM = IDLE.
  - Reset mid-frame aborts the frame; the line returns high immediately.
- Accept: a request is accepted in cycle N iff `wb_cyc` & `wb_stb` & !`wb_stall`.
  - `wb_ack` = 1 in cycle N+1 only; `wb_data_out` holds read data in N+1 and 0 otherwise.
  - Back-to-back accepts are allowed: one ack per accept, in order.
- Stall: `wb_stall` = `wb_stb` & `wb_we` & (`wb_addr`[3:2] == 0) & fifo_full, combinational on registered full.
  - No bypass: a pop in the same cycle does not lift the stall.
  - All other accesses never stall.
- Register map (`wb_addr`[3:2]):
  - 0 TXDATA: write pushes `wb_data_in`[7:0] at cycle N; entry is visible in N+1. Reads return 0.
  - 1 STATUS (read-only):
    - bit0 = busy (FSM != IDLE)
    - bit1 = full
    - bit2 = empty
    - bits[11:8] = fill count, 0..FIFO_DEPTH, width `HIGH_BIT_TO_FIT(FIFO_DEPTH)`+1.
    - Writes are acked and ignored.
  - 2 DIV: R/W, bits[15:0]; a write of 0 is stored as 1. Read returns the zero-extended stored value.
  - 3: reserved; reads 0, writes acked and ignored.
- `data_write_size` is ignored: TXDATA uses byte lane 0 and DIV uses bits [15:0] for any size.
- FIFO:
  - Circular buffer with read/write pointers of log2(FIFO_DEPTH) bits that wrap, plus a separate count.
  - Simultaneous push and pop when not full: count unchanged.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: if !empty, pop the head into a shift register, latch DIV into `bit_div`, and go to START next cycle.
  - START: `uart_tx` = 0 for `bit_div` cycles, then DATA.
  - DATA: LSB first, 8 bits of `bit_div` cycles each; bit counter 0..7.
  - STOP: `uart_tx` = 1 for `bit_div` cycles, then IDLE.
  - There is no idle gap when the FIFO is non-empty: the IDLE state lasts 1 cycle, which is added to the inter-frame time.
- DIV writes mid-frame do not affect the current frame; they apply at the next START.
- Latency: TXDATA accepted at N on empty FIFO with FSM in IDLE → pop at N+1 → `uart_tx` falls at N+2.
- `tx_irq` = empty & (FSM == IDLE), registered.

Decomposition:
- Shared constants package/header, included like `leiwand_rv32_constants.v`:
  - register offsets
  - STATUS bit positions
  - FSM state encodings
  - `UART_BASE` address (0x10000000) used by the top decoder.
- Sub-module `leiwand_rv32_sync_fifo`: parameterised width/depth, push/pop/full/empty/count. Reusable for a later RX path.

Test Plan:
1. Reset, DIV default:
   - Expected: `uart_tx` = 1; STATUS read returns 0x00000004.
   - Write TXDATA 0x55 at N: ack at N+1, `uart_tx` low at N+2.
   - Expected waveform: 10 bits of 104 cycles each, LSB first: 0,1,0,1,0,1,0,1,0,1.
2. DIV = 4; write 9 bytes back-to-back with `FIFO_DEPTH` = 8:
   - First pop frees a slot; check stall only while full.
   - All 9 bytes are transmitted in order, 41 cycles per frame.
   - STATUS count never exceeds 8.
3. Write DIV = 0, read DIV → 0x00000001. Write DIV = 0xABCD1234, read → 0x00001234.
4. Start a frame with DIV = 8, then write DIV = 2 mid-frame:
   - Current frame keeps 8-cycle bits; next frame uses 2-cycle bits.
5. Assert `reset` low during the DATA state:
   - `uart_tx` goes to 1 in the same cycle (async).
   - After release: FIFO empty, STATUS = 0x4, DIV = 104.
6. Accesses to offset 0xC and STATUS writes: acked next cycle, read 0, no state change.
   - Byte-size write (`data_write_size` = 1) to TXDATA transmits `wb_data_in`[7:0].

Source files
------------

// File: rtl/leiwand_rv32_wb_uart_tx_pkg.sv
// Shared constants for the Wishbone UART transmitter:
// register offsets, STATUS bit positions, FSM states, decoder base.
package leiwand_rv32_wb_uart_tx_pkg;

    localparam logic [31:0] UART_BASE = 32'h1000_0000;

    localparam logic [1:0] REG_TXDATA = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_DIV    = 2'd2;
    localparam logic [1:0] REG_RSVD   = 2'd3;

    localparam int ST_BUSY  = 0;
    localparam int ST_FULL  = 1;
    localparam int ST_EMPTY = 2;
    localparam int ST_COUNT = 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } tx_state_t;

    // Index of the highest bit needed to hold the value n.
    function automatic int high_bit_to_fit(input int n);
        return $clog2(n + 1) - 1;
    endfunction

endpackage

// File: rtl/leiwand_rv32_wb_uart_tx_if.sv
// Pipelined-Wishbone slave signal set shared with the RAM port.
// The master drives requests; the slave returns ack/stall/data.
interface leiwand_rv32_wb_uart_tx_if #(
    parameter int MEM_WIDTH = 32
);
    localparam int SW =
        leiwand_rv32_wb_uart_tx_pkg::high_bit_to_fit(4) + 1;

    logic [MEM_WIDTH-1:0] wb_addr;
    logic [MEM_WIDTH-1:0] wb_data_in;
    logic [MEM_WIDTH-1:0] wb_data_out;
    logic                 wb_we;
    logic                 wb_stb;
    logic                 wb_ack;
    logic                 wb_cyc;
    logic                 wb_stall;
    logic [SW-1:0]        data_write_size;

    modport master (
        output wb_addr, wb_data_in, wb_we,
        output wb_stb, wb_cyc, data_write_size,
        input  wb_data_out, wb_ack, wb_stall
    );

    modport slave (
        input  wb_addr, wb_data_in, wb_we,
        input  wb_stb, wb_cyc, data_write_size,
        output wb_data_out, wb_ack, wb_stall
    );

endinterface

// File: rtl/leiwand_rv32_sync_fifo.sv
// Synchronous circular-buffer FIFO with wrapping pointers and fill count.
// Pushes while full and pops while empty are ignored.
module leiwand_rv32_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= din;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop)  rptr <= rptr + AW'(1);
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/leiwand_rv32_wb_uart_tx.sv
// Wishbone UART transmitter: TX FIFO fed by CPU stores,
// serialised 8N1 onto uart_tx at a programmable bit period.
module leiwand_rv32_wb_uart_tx
    import leiwand_rv32_wb_uart_tx_pkg::*;
#(
    parameter int MEM_WIDTH  = 32,
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_RESET  = 104
) (
    input  logic                         clk,
    input  logic                         reset,
    leiwand_rv32_wb_uart_tx_if.slave     wb,
    output logic                         uart_tx,
    output logic                         tx_irq
);
    localparam int CW = high_bit_to_fit(FIFO_DEPTH) + 1;

    logic [1:0]           off;
    logic                 accept;
    logic                 push;
    logic                 pop;
    logic                 full;
    logic                 empty;
    logic [CW-1:0]        count;
    logic [7:0]           head;
    logic [15:0]          div;
    logic [MEM_WIDTH-1:0] rdata;
    logic                 busy;

    tx_state_t   state, state_n;
    logic [7:0]  shift, shift_n;
    logic [15:0] bit_div, bit_div_n;
    logic [15:0] cnt, cnt_n;
    logic [2:0]  idx, idx_n;
    logic        tx_n;
    logic        bit_end;

    logic unused_bits;
    assign unused_bits = ^{wb.data_write_size,
                           wb.wb_addr[MEM_WIDTH-1:4],
                           wb.wb_addr[1:0],
                           wb.wb_data_in[MEM_WIDTH-1:16]};

    assign off         = wb.wb_addr[3:2];
    assign wb.wb_stall = wb.wb_stb & wb.wb_we
                       & (off == REG_TXDATA) & full;
    assign accept      = wb.wb_cyc & wb.wb_stb & ~wb.wb_stall;
    assign push        = accept & wb.wb_we & (off == REG_TXDATA);
    assign busy        = (state != S_IDLE);

    leiwand_rv32_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (wb.wb_data_in[7:0]),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_comb begin
        rdata = '0;
        case (off)
            REG_STATUS: begin
                rdata[ST_BUSY]       = busy;
                rdata[ST_FULL]       = full;
                rdata[ST_EMPTY]      = empty;
                rdata[ST_COUNT +: CW] = count;
            end
            REG_DIV: rdata[15:0] = div;
            default: rdata = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wb.wb_ack      <= 1'b0;
            wb.wb_data_out <= '0;
            div            <= 16'(DIV_RESET);
        end else begin
            wb.wb_ack      <= accept;
            wb.wb_data_out <= (accept && !wb.wb_we) ? rdata : '0;
            if (accept && wb.wb_we && off == REG_DIV) begin
                // A zero period would never end a bit.
                div <= (wb.wb_data_in[15:0] == 16'd0) ?
                       16'd1 : wb.wb_data_in[15:0];
            end
        end
    end

    assign bit_end = (cnt == bit_div - 16'd1);

    always_comb begin
        state_n   = state;
        shift_n   = shift;
        bit_div_n = bit_div;
        cnt_n     = cnt;
        idx_n     = idx;
        pop       = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    shift_n   = head;
                    bit_div_n = div;
                    cnt_n     = '0;
                    state_n   = S_START;
                end
            end
            S_START: begin
                cnt_n = cnt + 16'd1;
                if (bit_end) begin
                    cnt_n   = '0;
                    idx_n   = '0;
                    state_n = S_DATA;
                end
            end
            S_DATA: begin
                cnt_n = cnt + 16'd1;
                if (bit_end) begin
                    cnt_n   = '0;
                    idx_n   = idx + 3'd1;
                    shift_n = {1'b0, shift[7:1]};
                    if (idx == 3'd7) state_n = S_STOP;
                end
            end
            S_STOP: begin
                cnt_n = cnt + 16'd1;
                if (bit_end) begin
                    cnt_n   = '0;
                    state_n = S_IDLE;
                end
            end
        endcase
        // Line level is registered alongside the state it belongs to.
        tx_n = 1'b1;
        if (state_n == S_START) tx_n = 1'b0;
        if (state_n == S_DATA)  tx_n = shift_n[0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            shift   <= '0;
            bit_div <= 16'd1;
            cnt     <= '0;
            idx     <= '0;
            uart_tx <= 1'b1;
            tx_irq  <= 1'b1;
        end else begin
            state   <= state_n;
            shift   <= shift_n;
            bit_div <= bit_div_n;
            cnt     <= cnt_n;
            idx     <= idx_n;
            uart_tx <= tx_n;
            tx_irq  <= empty & ~busy;
        end
    end

endmodule
